// File: rtl/ram_bus_arbiter_pkg.sv
// Shared types and constants for the CPU/DMA data-RAM arbiter.
// Holds the FSM state encoding, the grant identifiers and the default bus widths.
package mpp_bus_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;

  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/ram_bus_arbiter_if.sv
// Bundle of the CPU and DMA request ports plus the RAM strobe bus.
// The arbiter connects through the slave modport; requesters and the RAM use the master modport.
interface ram_bus_arbiter_if
  import mpp_bus_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_stall;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_ack;

  logic              ram_cs;
  logic              ram_rd;
  logic              ram_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_ack,
    output ram_cs, ram_rd, ram_wr, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_ack,
    input  ram_cs, ram_rd, ram_wr, ram_addr, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/ram_bus_arbiter_rr_arb2.sv
// Two-requester round-robin picker; bit 0 is the CPU, bit 1 the DMA port.
// On a tie the requester that did not win last time is chosen.
module rr_arb2
  import mpp_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = GRANT_CPU;
    if (req == 2'b11) begin
      gnt_id = ~last_grant;
    end else if (req[1]) begin
      gnt_id = GRANT_DMA;
    end
  end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Shared data-RAM sequencer: grants one master at a time and walks it through
// IDLE -> SETUP -> ACCESS (WAIT_CYCLES) -> DONE with registered RAM strobes.
module ram_bus_arbiter
  import mpp_bus_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = 1
)(
  input logic              clk,
  input logic              rst,
  ram_bus_arbiter_if.slave bus
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic              ram_cs_q, ram_cs_d;
  logic              ram_rd_q, ram_rd_d;
  logic              ram_wr_q, ram_wr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              dma_ack_q, dma_ack_d;

  logic              gnt_valid;
  logic              gnt_id;

  rr_arb2 u_rr_arb2 (
    .req        ({bus.dma_req, bus.cpu_req}),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  // Outputs are computed for the next state so every strobe leaves a flop.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    ram_cs_d     = 1'b0;
    ram_rd_d     = 1'b0;
    ram_wr_d     = 1'b0;
    cpu_ack_d    = 1'b0;
    dma_ack_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d  = SETUP;
          grant_d  = gnt_id;
          ram_cs_d = 1'b1;
          if (gnt_id == GRANT_DMA) begin
            we_d        = bus.dma_we;
            ram_addr_d  = bus.dma_addr;
            ram_wdata_d = bus.dma_wdata;
          end else begin
            we_d        = bus.cpu_we;
            ram_addr_d  = bus.cpu_addr;
            ram_wdata_d = bus.cpu_wdata;
          end
        end
      end
      SETUP: begin
        state_d  = ACCESS;
        cnt_d    = CNT_LOAD;
        ram_cs_d = 1'b1;
        ram_rd_d = ~we_q;
        ram_wr_d = we_q;
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d      = DONE;
          last_grant_d = grant_q;
          if (grant_q == GRANT_DMA) begin
            dma_ack_d = 1'b1;
            if (!we_q) dma_rdata_d = bus.ram_rdata;
          end else begin
            cpu_ack_d = 1'b1;
            if (!we_q) cpu_rdata_d = bus.ram_rdata;
          end
        end else begin
          cnt_d    = cnt_q - 4'd1;
          ram_cs_d = 1'b1;
          ram_rd_d = ~we_q;
          ram_wr_d = we_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      grant_q      <= GRANT_CPU;
      last_grant_q <= GRANT_DMA;
      we_q         <= 1'b0;
      ram_cs_q     <= 1'b0;
      ram_rd_q     <= 1'b0;
      ram_wr_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      dma_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      ram_cs_q     <= ram_cs_d;
      ram_rd_q     <= ram_rd_d;
      ram_wr_q     <= ram_wr_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      cpu_ack_q    <= cpu_ack_d;
      dma_ack_q    <= dma_ack_d;
    end
  end

  assign bus.ram_cs    = ram_cs_q;
  assign bus.ram_rd    = ram_rd_q;
  assign bus.ram_wr    = ram_wr_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.dma_ack   = dma_ack_q;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Bench for ram_bus_arbiter: three instances with WAIT_CYCLES 1, 3 and 4 share clock and reset.
// RAM read data is a fixed function of the address, returned only while ram_rd is high.
module tb_ram_bus_arbiter;
  import mpp_bus_pkg::*;

  localparam int   NDUT = 3;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        cpu_req   [NDUT];
  logic        cpu_we    [NDUT];
  logic [15:0] cpu_addr  [NDUT];
  logic [7:0]  cpu_wdata [NDUT];
  logic        dma_req   [NDUT];
  logic        dma_we    [NDUT];
  logic [15:0] dma_addr  [NDUT];
  logic [7:0]  dma_wdata [NDUT];

  wire [NDUT-1:0] cpu_ack_o, dma_ack_o, cpu_stall_o, ram_cs_o, ram_rd_o, ram_wr_o;
  wire [15:0]     ram_addr_o  [NDUT];
  wire [7:0]      ram_wdata_o [NDUT];
  wire [7:0]      cpu_rdata_o [NDUT];
  wire [7:0]      dma_rdata_o [NDUT];

  function automatic logic [7:0] ram_model(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hE5;
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    ram_bus_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();
    assign bus.cpu_req   = cpu_req[g];
    assign bus.cpu_we    = cpu_we[g];
    assign bus.cpu_addr  = cpu_addr[g];
    assign bus.cpu_wdata = cpu_wdata[g];
    assign bus.dma_req   = dma_req[g];
    assign bus.dma_we    = dma_we[g];
    assign bus.dma_addr  = dma_addr[g];
    assign bus.dma_wdata = dma_wdata[g];
    assign bus.ram_rdata = bus.ram_rd ? ram_model(bus.ram_addr) : 8'h00;

    ram_bus_arbiter #(
      .ADDR_W      (16),
      .DATA_W      (8),
      .WAIT_CYCLES (g == 0 ? 1 : (g == 1 ? 3 : 4))
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    assign cpu_ack_o[g]   = bus.cpu_ack;
    assign dma_ack_o[g]   = bus.dma_ack;
    assign cpu_stall_o[g] = bus.cpu_stall;
    assign ram_cs_o[g]    = bus.ram_cs;
    assign ram_rd_o[g]    = bus.ram_rd;
    assign ram_wr_o[g]    = bus.ram_wr;
    assign ram_addr_o[g]  = bus.ram_addr;
    assign ram_wdata_o[g] = bus.ram_wdata;
    assign cpu_rdata_o[g] = bus.cpu_rdata;
    assign dma_rdata_o[g] = bus.dma_rdata;
  end

  int checks   = 0;
  int failures = 0;

  task automatic checkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  task automatic checkw(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_cpu(input int d, input logic req, input logic we,
                         input logic [15:0] a, input logic [7:0] w);
    cpu_req[d] = req; cpu_we[d] = we; cpu_addr[d] = a; cpu_wdata[d] = w;
  endtask

  task automatic set_dma(input int d, input logic req, input logic we,
                         input logic [15:0] a, input logic [7:0] w);
    dma_req[d] = req; dma_we[d] = we; dma_addr[d] = a; dma_wdata[d] = w;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      set_cpu(d, L, L, 16'h0000, 8'h00);
      set_dma(d, L, L, 16'h0000, 8'h00);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic        rst;
    logic        creq, cwe;  logic [15:0] caddr; logic [7:0] cwd;
    logic        dreq, dwe;  logic [15:0] daddr; logic [7:0] dwd;
    logic        e_cs, e_rd, e_wr; logic [15:0] e_addr; logic [7:0] e_wd;
    logic        e_cack, e_dack, e_cst; logic [7:0] e_crd, e_drd;
  } vec_t;

  typedef struct {
    logic        id;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wd;
  } exp_t;

  vec_t vec_q[$];
  exp_t exp_cpu_q[$];
  exp_t exp_dma_q[$];
  logic order_q[$];
  logic sb_en = 1'b0;
  int   acks_seen = 0;
  exp_t mon_e;
  logic mon_id;

  // Scoreboard: every ack on instance 0 is matched against the predicted grant order.
  always @(negedge clk) begin
    if (sb_en && (cpu_ack_o[0] || dma_ack_o[0])) begin
      checkb("sb_ack_exclusive", cpu_ack_o[0] & dma_ack_o[0], 1'b0);
      mon_id = dma_ack_o[0];
      acks_seen++;
      if (order_q.size() > 0) checkb("sb_grant_order", mon_id, order_q.pop_front());
      if (mon_id ? (exp_dma_q.size() > 0) : (exp_cpu_q.size() > 0)) begin
        mon_e = mon_id ? exp_dma_q.pop_front() : exp_cpu_q.pop_front();
        checkw("sb_addr", ram_addr_o[0], mon_e.addr);
        if (mon_e.we) checkw("sb_wdata", {8'h00, ram_wdata_o[0]}, {8'h00, mon_e.wd});
        else checkw("sb_rdata", {8'h00, mon_id ? dma_rdata_o[0] : cpu_rdata_o[0]},
                    {8'h00, ram_model(mon_e.addr)});
      end
    end
  end

  task automatic run_master(input logic is_dma);
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      logic got;
      e.id   = is_dma;
      e.we   = is_dma ? ~k[0] : k[0];
      e.addr = is_dma ? 16'h0800 + 16'(k * 3) : 16'h0100 + 16'(k);
      e.wd   = is_dma ? 8'hC0 + 8'(k) : 8'h10 + 8'(k);
      if (is_dma) begin
        exp_dma_q.push_back(e);
        set_dma(0, H, e.we, e.addr, e.wd);
      end else begin
        exp_cpu_q.push_back(e);
        set_cpu(0, H, e.we, e.addr, e.wd);
      end
      got = 1'b0;
      for (int t = 0; t < 40 && !got; t++) begin
        @(negedge clk);
        got = is_dma ? dma_ack_o[0] : cpu_ack_o[0];
      end
      checkb(is_dma ? "dma_ack_timeout" : "cpu_ack_timeout", got, 1'b1);
      @(posedge clk);
      #1;
    end
    if (is_dma) set_dma(0, L, L, 16'h0000, 8'h00);
    else        set_cpu(0, L, L, 16'h0000, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    do_reset();

    // rst | cpu req/we/addr/wdata | dma req/we/addr/wdata | cs rd wr addr wdata | cack dack cstall | crdata drdata
    vec_q.push_back('{L, H,L,16'h0040,8'h00, L,L,16'h0000,8'h00, L,L,L,16'h0000,8'h00, L,L,H, 8'h00,8'h00});
    vec_q.push_back('{L, H,L,16'h0040,8'h00, L,L,16'h0000,8'h00, H,L,L,16'h0040,8'h00, L,L,H, 8'h00,8'h00});
    vec_q.push_back('{L, H,L,16'h0040,8'h00, L,L,16'h0000,8'h00, H,H,L,16'h0040,8'h00, L,L,H, 8'h00,8'h00});
    vec_q.push_back('{L, H,L,16'h0040,8'h00, L,L,16'h0000,8'h00, L,L,L,16'h0040,8'h00, H,L,L, 8'hA5,8'h00});
    vec_q.push_back('{L, L,L,16'h0000,8'h00, L,L,16'h0000,8'h00, L,L,L,16'h0040,8'h00, L,L,L, 8'hA5,8'h00});
    vec_q.push_back('{H, L,L,16'h0000,8'h00, L,L,16'h0000,8'h00, L,L,L,16'h0040,8'h00, L,L,L, 8'hA5,8'h00});
    vec_q.push_back('{L, H,L,16'h0102,8'h00, H,L,16'h0203,8'h00, L,L,L,16'h0000,8'h00, L,L,H, 8'h00,8'h00});
    vec_q.push_back('{L, H,L,16'h0102,8'h00, H,L,16'h0203,8'h00, H,L,L,16'h0102,8'h00, L,L,H, 8'h00,8'h00});
    vec_q.push_back('{L, H,L,16'h0102,8'h00, H,L,16'h0203,8'h00, H,H,L,16'h0102,8'h00, L,L,H, 8'h00,8'h00});
    vec_q.push_back('{L, H,L,16'h0102,8'h00, H,L,16'h0203,8'h00, L,L,L,16'h0102,8'h00, H,L,L, 8'hE6,8'h00});
    vec_q.push_back('{L, L,L,16'h0000,8'h00, H,L,16'h0203,8'h00, L,L,L,16'h0102,8'h00, L,L,L, 8'hE6,8'h00});
    vec_q.push_back('{L, L,L,16'h0000,8'h00, H,L,16'h0203,8'h00, H,L,L,16'h0203,8'h00, L,L,L, 8'hE6,8'h00});
    vec_q.push_back('{L, L,L,16'h0000,8'h00, H,L,16'h0203,8'h00, H,H,L,16'h0203,8'h00, L,L,L, 8'hE6,8'h00});
    vec_q.push_back('{L, L,L,16'h0000,8'h00, H,L,16'h0203,8'h00, L,L,L,16'h0203,8'h00, L,H,L, 8'hE6,8'hE4});
    vec_q.push_back('{L, L,L,16'h0000,8'h00, L,L,16'h0000,8'h00, L,L,L,16'h0203,8'h00, L,L,L, 8'hE6,8'hE4});
    vec_q.push_back('{L, H,H,16'h0050,8'h3C, L,L,16'h0000,8'h00, L,L,L,16'h0203,8'h00, L,L,H, 8'hE6,8'hE4});
    vec_q.push_back('{L, H,H,16'h0050,8'h3C, L,L,16'h0000,8'h00, H,L,L,16'h0050,8'h3C, L,L,H, 8'hE6,8'hE4});
    vec_q.push_back('{L, H,H,16'h0050,8'h3C, L,L,16'h0000,8'h00, H,L,H,16'h0050,8'h3C, L,L,H, 8'hE6,8'hE4});
    vec_q.push_back('{L, H,H,16'h0050,8'h3C, L,L,16'h0000,8'h00, L,L,L,16'h0050,8'h3C, H,L,L, 8'hE6,8'hE4});
    vec_q.push_back('{L, L,L,16'h0000,8'h00, L,L,16'h0000,8'h00, L,L,L,16'h0050,8'h3C, L,L,L, 8'hE6,8'hE4});

    foreach (vec_q[i]) begin
      vec_t v;
      v   = vec_q[i];
      rst = v.rst;
      set_cpu(0, v.creq, v.cwe, v.caddr, v.cwd);
      set_dma(0, v.dreq, v.dwe, v.daddr, v.dwd);
      @(negedge clk);
      checkb($sformatf("v%0d_cs", i), ram_cs_o[0], v.e_cs);
      checkb($sformatf("v%0d_rd", i), ram_rd_o[0], v.e_rd);
      checkb($sformatf("v%0d_wr", i), ram_wr_o[0], v.e_wr);
      checkw($sformatf("v%0d_addr", i), ram_addr_o[0], v.e_addr);
      checkw($sformatf("v%0d_wdata", i), {8'h00, ram_wdata_o[0]}, {8'h00, v.e_wd});
      checkb($sformatf("v%0d_cpu_ack", i), cpu_ack_o[0], v.e_cack);
      checkb($sformatf("v%0d_dma_ack", i), dma_ack_o[0], v.e_dack);
      checkb($sformatf("v%0d_cpu_stall", i), cpu_stall_o[0], v.e_cst);
      checkw($sformatf("v%0d_cpu_rdata", i), {8'h00, cpu_rdata_o[0]}, {8'h00, v.e_crd});
      checkw($sformatf("v%0d_dma_rdata", i), {8'h00, dma_rdata_o[0]}, {8'h00, v.e_drd});
      @(posedge clk);
      #1;
      rst = 1'b0;
    end

    // DMA write on the WAIT_CYCLES=3 instance.
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      set_dma(1, (c <= 5), H, 16'h1234, 8'h5A);
      @(negedge clk);
      checkb($sformatf("dw_c%0d_wr", c), ram_wr_o[1], (c >= 2 && c <= 4));
      checkb($sformatf("dw_c%0d_rd", c), ram_rd_o[1], 1'b0);
      checkb($sformatf("dw_c%0d_cs", c), ram_cs_o[1], (c >= 1 && c <= 4));
      checkb($sformatf("dw_c%0d_ack", c), dma_ack_o[1], (c == 5));
      checkw($sformatf("dw_c%0d_rdata", c), {8'h00, dma_rdata_o[1]}, 16'h0000);
      if (c >= 1 && c <= 5) begin
        checkw($sformatf("dw_c%0d_addr", c), ram_addr_o[1], 16'h1234);
        checkw($sformatf("dw_c%0d_wdata", c), {8'h00, ram_wdata_o[1]}, 16'h005A);
      end
      @(posedge clk);
      #1;
    end

    // Reset in the middle of a CPU write on the WAIT_CYCLES=4 instance.
    do_reset();
    set_cpu(2, H, H, 16'h0777, 8'h99);
    for (int c = 0; c <= 7; c++) begin
      if (c == 3) rst = 1'b1;
      @(negedge clk);
      checkb($sformatf("ra_c%0d_cs", c), ram_cs_o[2], (c >= 1 && c <= 3));
      checkb($sformatf("ra_c%0d_wr", c), ram_wr_o[2], (c >= 2 && c <= 3));
      checkb($sformatf("ra_c%0d_ack", c), cpu_ack_o[2], 1'b0);
      if (c >= 4) checkw($sformatf("ra_c%0d_addr", c), ram_addr_o[2], 16'h0000);
      @(posedge clk);
      #1;
      rst = 1'b0;
      if (c == 3) set_cpu(2, L, L, 16'h0000, 8'h00);
    end
    set_cpu(2, H, L, 16'h0040, 8'h00);
    set_dma(2, H, L, 16'h0203, 8'h00);
    for (int c = 8; c <= 14; c++) begin
      @(negedge clk);
      checkb($sformatf("ra_c%0d_cpu_ack", c), cpu_ack_o[2], (c == 14));
      checkb($sformatf("ra_c%0d_dma_ack", c), dma_ack_o[2], 1'b0);
      checkb($sformatf("ra_c%0d_cs", c), ram_cs_o[2], (c >= 9 && c <= 13));
      @(posedge clk);
      #1;
    end
    checkw("ra_cpu_rdata", {8'h00, cpu_rdata_o[2]}, 16'h00A5);

    // Request held past the ack on the WAIT_CYCLES=1 instance.
    do_reset();
    for (int c = 0; c <= 9; c++) begin
      set_cpu(0, (c <= 7), L, (c <= 3) ? 16'h0011 : 16'h0022, 8'h00);
      @(negedge clk);
      checkb($sformatf("hr_c%0d_cs", c), ram_cs_o[0], (c == 1 || c == 2 || c == 5 || c == 6));
      checkb($sformatf("hr_c%0d_ack", c), cpu_ack_o[0], (c == 3 || c == 7));
      checkw($sformatf("hr_c%0d_rdata", c), {8'h00, cpu_rdata_o[0]},
             {8'h00, (c >= 7) ? 8'hC7 : ((c >= 3) ? 8'hF4 : 8'h00)});
      @(posedge clk);
      #1;
    end

    // Continuous contention: eight accesses that must alternate starting with the CPU.
    do_reset();
    for (int k = 0; k < 8; k++) order_q.push_back(k[0]);
    acks_seen = 0;
    sb_en = 1'b1;
    fork
      run_master(1'b0);
      run_master(1'b1);
    join
    repeat (2) @(negedge clk);
    sb_en = 1'b0;
    checkw("sb_ack_count", 16'(acks_seen), 16'd8);
    checkw("sb_cpu_left", 16'(exp_cpu_q.size()), 16'd0);
    checkw("sb_dma_left", 16'(exp_dma_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_bus_arbiter.md
# ram_bus_arbiter

Sequencer and arbiter for the shared data RAM of the 8-bit microprogrammed CPU. It accepts memory requests from two masters: the CPU, driven by the RAMcs/RAMrd/RAMwr microcode fields of the control unit, and a DMA/IO port. It grants the RAM to one master at a time and generates the RAM cs/rd/wr strobe sequence. While a CPU access is pending it stalls the CPU microsequencer.

## Interface
Parameters:
- ADDR_W, 16: RAM address width (PCH:PCL / DIR composed).
- DATA_W, 8: data bus width.
- WAIT_CYCLES, 1: cycles the rd/wr strobe is held. Legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request. Level signal, held until ack.
- cpu_we  in  1  1 = write, 0 = read. Stable while cpu_req is high.
- cpu_addr  in  ADDR_W  CPU address. Stable while cpu_req is high.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  last data read for the CPU.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_stall  out  1  cpu_req & ~cpu_ack (combinational). Gates the microsequencer clock enable.
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack: same semantics and widths for the DMA/IO master.
- ram_cs  out  1  RAM chip select.
- ram_rd  out  1  RAM read strobe.
- ram_wr  out  1  RAM write strobe.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid during the strobe.

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE.
- **IDLE.** Sample cpu_req and dma_req.
  - If only one request is high, grant it.
  - If both are high, grant the master other than last_grant (round-robin).
  - If neither is high, stay in IDLE.
  - On grant: latch grant, we, addr and wdata of the winner; go to SETUP.
- **SETUP (1 cycle).** ram_cs=1, ram_addr/ram_wdata driven from the latch, rd=wr=0.
- **ACCESS (WAIT_CYCLES cycles).** ram_cs=1, ram_rd=~we, ram_wr=we.
  - The 4-bit wait counter is loaded with WAIT_CYCLES-1 on SETUP exit and decrements each cycle.
  - Exit to DONE when the counter is 0.
  - On a read, ram_rdata is captured into the granted master's rdata register at the exit edge.
- **DONE (1 cycle).** ram_cs=rd=wr=0, ram_addr held. The granted master's ack=1; last_grant updated. Next state is IDLE.
- Requester protocol: the master drops req on the edge where it samples ack=1. A req still high in the following IDLE cycle is a new request.
- rdata registers hold their value until the next completed read by the same master. Writes do not modify them.
- The non-granted master's req, addr and data are ignored until the next IDLE.
- Requests arriving in SETUP, ACCESS or DONE wait; there is no preemption.
- ack is never asserted to both masters in the same cycle.

## Timing
- Latency: req high in IDLE at cycle n gives SETUP at n+1, ACCESS at n+2..n+1+WAIT_CYCLES, DONE/ack at n+2+WAIT_CYCLES. With WAIT_CYCLES=1, ack arrives at n+3.
- Back-to-back throughput: one access per WAIT_CYCLES+3 cycles (IDLE, SETUP, ACCESS, DONE).
- Simultaneous requests alternate grants. Worst-case wait for a master is one foreign access.
- Reset values: ram_cs=ram_rd=ram_wr=0; ram_addr=0; ram_wdata=0; cpu_rdata=dma_rdata=0; acks=0; state=IDLE; last_grant=DMA, so the CPU wins the first tie.
- Reset mid-access: strobes are low from the cycle after the reset edge. No ack is issued for the aborted access and rdata is unchanged. The master re-requests after reset.
- The strobe never rises in the same cycle as an address change: addr is stable from SETUP through DONE.

## Structure
- Package mpp_bus_pkg holds:
  - the state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, DONE=2'd3);
  - GRANT_CPU=1'b0 and GRANT_DMA=1'b1;
  - default ADDR_W and DATA_W.
- Sub-module rr_arb2: a two-requester round-robin picker.
  - Inputs: req[1:0], last_grant. Outputs: gnt_valid, gnt_id.
  - Purely combinational; last_grant lives in ram_bus_arbiter.

## Test plan
- CPU read, WAIT_CYCLES=1: cpu_req=1, we=0, addr=16'h0040 at cycle 0; RAM returns 8'hA5. Expect ram_rd=1 in cycle 2 only, cpu_ack in cycle 3, cpu_rdata=8'hA5, cpu_stall high in cycles 0-2.
- DMA write, WAIT_CYCLES=3: addr=16'h1234, wdata=8'h5A. Expect ram_wr high in cycles 2-4, addr/wdata stable cycles 1-5, dma_ack in cycle 5, dma_rdata unchanged.
- Tie after reset: cpu_req and dma_req both high at cycle 0. Expect the CPU granted first (ack cycle 3), then DMA (SETUP cycle 5, ack cycle 7).
- Continuous contention, 8 accesses: grants strictly alternate CPU/DMA, and no cycle has cpu_ack & dma_ack.
- Reset asserted in ACCESS of a CPU write (WAIT_CYCLES=4): ram_wr=0 and cs=0 in the cycle after reset, no cpu_ack, state IDLE, and the next tie goes to the CPU.
- Held req after ack: cpu_req kept high one cycle past ack starts a second access. Expect SETUP two cycles after the first ack.
